rca_modport: RTL and testbench
==============================

Name: rca_modport

Overview:
- Parameterised N-bit ripple-carry adder: A + B + Cin -> {Cout, SUM}.
- The adder core is a pure combinational chain of N full-adder cells.
- Result is captured in an output register clocked by clk, giving one-cycle timing toward the rest of the design.
- Sits behind the team's rca interface port group: A, B and Cin in; SUM and Cout out.

Parameters:
- N, default 2, operand and sum width in bits; legal range N >= 1.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  A, B and Cin are valid this cycle.
- A  input  N  operand A, unsigned.
- B  input  N  operand B, unsigned.
- Cin  input  1  carry-in to bit 0.
- out_valid  output  1  SUM and Cout hold a registered result.
- SUM  output  N  registered sum bits [N-1:0].
- Cout  output  1  registered carry-out of bit N-1.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). No asynchronous paths to state.
- Reset:
  - When rst = 1 at a rising edge: SUM = 0, Cout = 0, out_valid = 0.
  - Reset has priority over in_valid in the same cycle.
  - Reset mid-stream discards any result in flight.
- Combinational core:
  - c[0] = Cin.
  - For i = 0..N-1: s[i] = A[i] ^ B[i] ^ c[i]; c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i])).
  - Cout_next = c[N].
- Arithmetic:
  - {Cout_next, s} equals the (N+1)-bit unsigned value A + B + Cin exactly.
  - No saturation; wrap-around is expressed only through Cout.
- Latency and valid handshake:
  - At a rising edge with rst = 0 and in_valid = 1: SUM <= s, Cout <= c[N], out_valid <= 1.
  - At a rising edge with rst = 0 and in_valid = 0: out_valid <= 0, and SUM/Cout hold their previous values.
  - Latency is exactly 1 cycle; throughput is one operation per cycle.
  - No backpressure; the downstream block must consume the result in the cycle out_valid = 1.
- Boundary conditions:
  - All-ones + all-ones + 1 -> SUM = all-ones, Cout = 1.
  - 0 + 0 + 0 -> SUM = 0, Cout = 0.
  - Full carry propagate: A = all-ones, B = 0, Cin = 1 -> SUM = 0, Cout = 1.
  - N = 1 degenerates to a single registered full adder.
- X handling: inputs are ignored entirely when in_valid = 0 and must not corrupt SUM or Cout.

Optional Feature:
- Macro: RCA_SVA_EN.
- When defined (simulation only), bound concurrent assertions check:
  - Arithmetic correctness: past(in_valid && !rst) implies {Cout, SUM} == past(A + B + Cin).
  - Reset clears state: past(rst) implies out_valid == 0, SUM == 0 and Cout == 0.
  - Hold behaviour: past(!in_valid && !rst) implies SUM and Cout are stable.
  - No X on SUM or Cout while out_valid = 1.
- When not defined: no assertion code is compiled, and there is zero functional or area impact.

Decomposition:
- Package rca_pkg holds:
  - Default width constant RCA_N_DEF = 2.
  - Typedef for the result struct {logic cout; logic [N-1:0] sum}, with the width supplied locally.
- One sub-module: rca_full_adder (1-bit cell: a, b, cin -> s, cout).
  - Instantiated N times via a generate loop.
  - Carries chain between adjacent cells.

Test Plan:
- Reset: hold rst = 1 for 2 cycles with in_valid = 1, A = 3, B = 3 -> out_valid = 0, SUM = 0, Cout = 0. Release rst -> first result appears 1 cycle after the first valid input.
- N = 2 max case: A = 3, B = 3, Cin = 1 -> next cycle SUM = 3, Cout = 1, out_valid = 1.
- N = 2 simple case: A = 1, B = 2, Cin = 0 -> SUM = 3, Cout = 0. Then A = 2, B = 2, Cin = 0 -> SUM = 0, Cout = 1.
- Carry propagate, N = 8: A = 8'hFF, B = 8'h00, Cin = 1 -> SUM = 8'h00, Cout = 1. Then A = 8'h80, B = 8'h80, Cin = 0 -> SUM = 8'h00, Cout = 1.
- Hold: valid result SUM = 3, then in_valid = 0 with A/B toggling randomly -> SUM stays 3, Cout unchanged, out_valid = 0.
- Exhaustive, N = 2: all 32 combinations back-to-back with in_valid = 1 -> each result equals A + B + Cin exactly one cycle later. Assert rst mid-sequence -> outputs cleared, and the sequence resumes correctly after release.

Source files
------------

// File: rtl/rca_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rca_pkg
// Description : Shared constants and types for the ripple-carry adder slice.
// Revision    : 1.0 - initial release
// ============================================================================
package rca_pkg;

    localparam int RCA_N_DEF = 2;

    // Result at the default width. Other widths declare the same layout locally.
    typedef struct packed {
        logic                 cout;
        logic [RCA_N_DEF-1:0] sum;
    } rca_result_def_t;

endpackage : rca_pkg
`default_nettype wire

// File: rtl/rca_full_adder.sv
`default_nettype none
// ============================================================================
// Module      : rca_full_adder
// Description : One-bit full-adder cell, the building block of the carry chain.
// Revision    : 1.0 - initial release
// ============================================================================
module rca_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic half_sum;

    assign half_sum = a ^ b;
    assign s        = half_sum ^ cin;
    assign cout     = (a & b) | (cin & half_sum);

endmodule : rca_full_adder
`default_nettype wire

// File: rtl/rca_modport.sv
`default_nettype none
// ============================================================================
// Module      : rca_modport
// Description : N-bit ripple-carry adder with a registered {Cout, SUM} result.
//               Define RCA_SVA_EN to compile the simulation-only assertions.
// Revision    : 1.0 - initial release
// ============================================================================
module rca_modport
    import rca_pkg::*;
#(
    parameter int N = RCA_N_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    output logic         out_valid,
    output logic [N-1:0] SUM,
    output logic         Cout
);

    typedef struct packed {
        logic         cout;
        logic [N-1:0] sum;
    } rca_result_t;

    logic [N:0]   carry;
    logic [N-1:0] sum_comb;

    assign carry[0] = Cin;

    generate
        for (genvar i = 0; i < N; i++) begin : g_bit
            rca_full_adder u_fa (
                .a    (A[i]),
                .b    (B[i]),
                .cin  (carry[i]),
                .s    (sum_comb[i]),
                .cout (carry[i+1])
            );
        end
    endgenerate

    rca_result_t result_d, result_q;
    logic        valid_d, valid_q;

    // The result register only loads on valid input so idle cycles hold it.
    always_comb begin
        result_d = result_q;
        valid_d  = 1'b0;
        if (in_valid) begin
            result_d.sum  = sum_comb;
            result_d.cout = carry[N];
            valid_d       = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    assign out_valid = valid_q;
    assign SUM       = result_q.sum;
    assign Cout      = result_q.cout;

`ifdef RCA_SVA_EN
    a_arith : assert property (@(posedge clk)
        $past(in_valid && !rst) |->
            {Cout, SUM} == $past({1'b0, A} + {1'b0, B} + {{N{1'b0}}, Cin}));

    a_reset : assert property (@(posedge clk)
        $past(rst) |-> (!out_valid && SUM == '0 && !Cout));

    a_hold : assert property (@(posedge clk)
        $past(!in_valid && !rst) |-> ($stable(SUM) && $stable(Cout)));

    a_no_x : assert property (@(posedge clk)
        out_valid |-> !$isunknown({Cout, SUM}));
`endif

endmodule : rca_modport
`default_nettype wire

// File: tb/tb_rca_modport.sv
`default_nettype none
// ============================================================================
// Module      : tb_rca_modport
// Description : Self-checking bench for rca_modport at N = 2 and N = 8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rca_modport;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [1:0] a2, b2;
    logic       cin2;
    logic [7:0] a8, b8;
    logic       cin8;

    logic       ov2, cout2, ov8, cout8;
    logic [1:0] sum2;
    logic [7:0] sum8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rca_modport #(.N(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .A(a2), .B(b2), .Cin(cin2),
        .out_valid(ov2), .SUM(sum2), .Cout(cout2)
    );

    rca_modport #(.N(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .A(a8), .B(b8), .Cin(cin8),
        .out_valid(ov8), .SUM(sum8), .Cout(cout8)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: integer sum of the operands, loaded on valid input.
    int   exp2_val, exp8_val;
    logic exp_valid;
    bit   model_live = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            exp2_val   <= 0;
            exp8_val   <= 0;
            exp_valid  <= 1'b0;
            model_live <= 1'b1;
        end else if (in_valid) begin
            exp2_val  <= int'(a2) + int'(b2) + int'(cin2);
            exp8_val  <= int'(a8) + int'(b8) + int'(cin8);
            exp_valid <= 1'b1;
        end else begin
            exp_valid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            chk("model_valid2", 32'(ov2), 32'(exp_valid));
            chk("model_res2",   32'({cout2, sum2}), 32'(exp2_val));
            chk("model_valid8", 32'(ov8), 32'(exp_valid));
            chk("model_res8",   32'({cout8, sum8}), 32'(exp8_val));
        end
    end

    task automatic drive(input logic v, input logic [1:0] a, input logic [1:0] b, input logic c,
                         input logic [7:0] x, input logic [7:0] y, input logic z);
        in_valid = v;
        a2 = a; b2 = b; cin2 = c;
        a8 = x; b8 = y; cin8 = z;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b1, 2'd3, 2'd3, 1'b1, 8'hFF, 8'hFF, 1'b1);
        @(negedge clk);
        chk("rst_valid", 32'(ov2), 32'd0);
        chk("rst_sum",   32'(sum2), 32'd0);
        chk("rst_cout",  32'(cout2), 32'd0);
        chk("rst_sum8",  32'(sum8), 32'd0);

        rst = 1'b0;
        drive(1'b1, 2'd3, 2'd3, 1'b1, 8'hFF, 8'h00, 1'b1);
        chk("max_valid", 32'(ov2), 32'd1);
        chk("max_sum",   32'(sum2), 32'd3);
        chk("max_cout",  32'(cout2), 32'd1);
        chk("prop_sum8", 32'(sum8), 32'h00);
        chk("prop_cout8", 32'(cout8), 32'd1);

        drive(1'b1, 2'd1, 2'd2, 1'b0, 8'h80, 8'h80, 1'b0);
        chk("simple_sum",  32'(sum2), 32'd3);
        chk("simple_cout", 32'(cout2), 32'd0);
        chk("msb_sum8",    32'(sum8), 32'h00);
        chk("msb_cout8",   32'(cout8), 32'd1);

        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 2'($urandom), 2'($urandom), 1'($urandom),
                  8'($urandom), 8'($urandom), 1'($urandom));
            chk("hold_valid", 32'(ov2), 32'd0);
            chk("hold_sum",   32'(sum2), 32'd3);
            chk("hold_cout",  32'(cout2), 32'd0);
            chk("hold_sum8",  32'(sum8), 32'h00);
        end

        drive(1'b1, 2'd2, 2'd2, 1'b0, 8'h00, 8'h00, 1'b0);
        chk("wrap_sum",   32'(sum2), 32'd0);
        chk("wrap_cout",  32'(cout2), 32'd1);
        chk("zero_sum8",  32'(sum8), 32'h00);
        chk("zero_cout8", 32'(cout8), 32'd0);

        // All 32 N=2 combinations back to back, with a reset pulse mid-way.
        for (int k = 0; k < 32; k++) begin
            if (k == 16) begin
                rst = 1'b1;
                drive(1'b1, 2'd3, 2'd3, 1'b1, 8'hAA, 8'h55, 1'b1);
                chk("mid_rst_valid", 32'(ov2), 32'd0);
                chk("mid_rst_res",   32'({cout2, sum2}), 32'd0);
                rst = 1'b0;
            end
            drive(1'b1, 2'(k >> 3), 2'(k >> 1), 1'(k),
                  8'($urandom), 8'($urandom), 1'($urandom));
            if (k == 16)
                chk("resume_res", 32'({cout2, sum2}), 32'd2);
        end

        for (int i = 0; i < 300; i++) begin
            rst = ($urandom_range(0, 31) == 0);
            drive(1'($urandom), 2'($urandom), 2'($urandom), 1'($urandom),
                  8'($urandom), 8'($urandom), 1'($urandom));
        end
        rst = 1'b0;
        drive(1'b1, 2'd3, 2'd3, 1'b1, 8'hFF, 8'hFF, 1'b1);
        chk("ones_sum8",  32'(sum8), 32'hFF);
        chk("ones_cout8", 32'(cout8), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_rca_modport
`default_nettype wire
